// File: rtl/branch_update_queue.sv
// branch_update_queue: in-order tracker for predicted branches between fetch
// and the predictor update port. Fetch allocates up to two entries per cycle,
// execute resolves them out of order by tag, and resolved entries drain in
// program order (up to two per cycle) onto registered update outputs. A wrong
// prediction at drain raises a one-cycle redirect and squashes younger entries.
// Optional statistics counters are enabled by defining BUQ_STATS_EN.
module branch_update_queue #(
    parameter int DEPTH = 16,
    parameter int TAG_W = $clog2(DEPTH)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [1:0]            alloc_valid,
    input  logic [1:0][31:0]      alloc_PC,
    input  logic [1:0]            alloc_pred_dir,
    input  logic [1:0][31:0]      alloc_pred_target,
    output logic                  alloc_ready,
    output logic [1:0][TAG_W-1:0] alloc_tag,
    input  logic [1:0]            resolve_valid,
    input  logic [1:0][TAG_W-1:0] resolve_tag,
    input  logic [1:0]            resolve_dir,
    input  logic [1:0][31:0]      resolve_target,
    output logic [1:0]            valid_update,
    output logic [1:0][31:0]      PC_update,
    output logic [1:0]            direction_update,
    output logic [1:0][31:0]      target_update,
    output logic                  mispredict,
    output logic [31:0]           redirect_PC,
    output logic [TAG_W:0]        count,
    output logic [31:0]           stat_branches,
    output logic [31:0]           stat_mispredicts
);

    // A taken branch must also match its target; a not-taken one only its direction.
    function automatic logic is_mispred(input logic pdir, input logic adir,
                                        input logic [31:0] ptgt, input logic [31:0] atgt);
        return (pdir != adir) || (adir && (ptgt != atgt));
    endfunction

    function automatic logic [31:0] redirect_of(input logic adir, input logic [31:0] pc,
                                                input logic [31:0] atgt);
        return adir ? atgt : pc + 32'd4;
    endfunction

    logic [DEPTH-1:0] valid_q, valid_d, resolved_q, resolved_d;
    logic [31:0]      pc_q   [DEPTH];
    logic             pdir_q [DEPTH];
    logic [31:0]      ptgt_q [DEPTH];
    logic             adir_q [DEPTH];
    logic [31:0]      atgt_q [DEPTH];

    logic [TAG_W-1:0] head_q, head_d, tail_q, tail_d, h0, h1;
    logic [TAG_W:0]   count_q, count_d, n_alloc, n_drain;
    logic [1:0]       alloc_en;
    logic             drain0, drain1, mis0, mis1, squash;

    logic [1:0]       vupd_q;
    logic [1:0][31:0] pcupd_q, tgtupd_q;
    logic [1:0]       dirupd_q;
    logic             mispredict_q;
    logic [31:0]      redirect_q;

    // Allocation, drain selection and next pointer/occupancy state.
    always_comb begin
        alloc_ready  = (count_q <= (TAG_W+1)'(DEPTH - 2));
        alloc_tag[0] = tail_q;
        alloc_tag[1] = alloc_valid[0] ? tail_q + TAG_W'(1) : tail_q;
        alloc_en     = alloc_valid & {2{alloc_ready}};

        h0     = head_q;
        h1     = head_q + TAG_W'(1);
        drain0 = valid_q[h0] && resolved_q[h0];
        mis0   = drain0 && is_mispred(pdir_q[h0], adir_q[h0], ptgt_q[h0], atgt_q[h0]);
        drain1 = drain0 && !mis0 && valid_q[h1] && resolved_q[h1];
        mis1   = drain1 && is_mispred(pdir_q[h1], adir_q[h1], ptgt_q[h1], atgt_q[h1]);
        squash = mis0 || mis1;

        n_alloc = (TAG_W+1)'(alloc_en[0]) + (TAG_W+1)'(alloc_en[1]);
        n_drain = (TAG_W+1)'(drain0) + (TAG_W+1)'(drain1);
        head_d  = head_q + TAG_W'(n_drain);
        tail_d  = squash ? head_d : tail_q + TAG_W'(n_alloc);
        count_d = squash ? '0 : count_q + n_alloc - n_drain;

        valid_d    = valid_q;
        resolved_d = resolved_q;
        if (drain0) valid_d[h0] = 1'b0;
        if (drain1) valid_d[h1] = 1'b0;
        if (squash) begin
            // Everything younger than the mispredicted entry is discarded.
            valid_d = '0;
        end else begin
            for (int s = 0; s < 2; s++) begin
                if (resolve_valid[s] && valid_q[resolve_tag[s]])
                    resolved_d[resolve_tag[s]] = 1'b1;
            end
            for (int s = 0; s < 2; s++) begin
                if (alloc_en[s]) begin
                    valid_d[alloc_tag[s]]    = 1'b1;
                    resolved_d[alloc_tag[s]] = 1'b0;
                end
            end
        end
    end

    // Control state and registered update/redirect outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q      <= '0;
            resolved_q   <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            vupd_q       <= '0;
            pcupd_q      <= '0;
            dirupd_q     <= '0;
            tgtupd_q     <= '0;
            mispredict_q <= 1'b0;
            redirect_q   <= '0;
        end else begin
            valid_q      <= valid_d;
            resolved_q   <= resolved_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            vupd_q       <= {drain1, drain0};
            pcupd_q[0]   <= drain0 ? pc_q[h0]   : 32'd0;
            dirupd_q[0]  <= drain0 ? adir_q[h0] : 1'b0;
            tgtupd_q[0]  <= drain0 ? atgt_q[h0] : 32'd0;
            pcupd_q[1]   <= drain1 ? pc_q[h1]   : 32'd0;
            dirupd_q[1]  <= drain1 ? adir_q[h1] : 1'b0;
            tgtupd_q[1]  <= drain1 ? atgt_q[h1] : 32'd0;
            mispredict_q <= squash;
            redirect_q   <= mis0 ? redirect_of(adir_q[h0], pc_q[h0], atgt_q[h0]) :
                            mis1 ? redirect_of(adir_q[h1], pc_q[h1], atgt_q[h1]) : 32'd0;
        end
    end

    // Entry payload; only meaningful while the entry's valid bit is set.
    always_ff @(posedge clock) begin
        for (int s = 0; s < 2; s++) begin
            if (resolve_valid[s] && valid_q[resolve_tag[s]]) begin
                adir_q[resolve_tag[s]] <= resolve_dir[s];
                atgt_q[resolve_tag[s]] <= resolve_target[s];
            end
        end
        for (int s = 0; s < 2; s++) begin
            if (alloc_en[s]) begin
                pc_q[alloc_tag[s]]   <= alloc_PC[s];
                pdir_q[alloc_tag[s]] <= alloc_pred_dir[s];
                ptgt_q[alloc_tag[s]] <= alloc_pred_target[s];
            end
        end
    end

    assign valid_update     = vupd_q;
    assign PC_update        = pcupd_q;
    assign direction_update = dirupd_q;
    assign target_update    = tgtupd_q;
    assign mispredict       = mispredict_q;
    assign redirect_PC      = redirect_q;
    assign count            = count_q;

`ifdef BUQ_STATS_EN
    logic [31:0] stat_br_q, stat_mis_q;

    // Drained-branch and mispredict counters, free-running with wrap.
    always_ff @(posedge clock) begin
        if (reset) begin
            stat_br_q  <= '0;
            stat_mis_q <= '0;
        end else begin
            stat_br_q  <= stat_br_q + 32'(n_drain);
            stat_mis_q <= stat_mis_q + 32'(squash);
        end
    end

    assign stat_branches    = stat_br_q;
    assign stat_mispredicts = stat_mis_q;
`else
    assign stat_branches    = 32'd0;
    assign stat_mispredicts = 32'd0;
`endif

endmodule
